// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module : branch_predictor_pkg
// Brief  : Shared counter encodings and constants for the gshare predictor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef BP_CNT_INIT
`define BP_CNT_INIT 2'b01
`endif

package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  localparam logic [1:0] c_cnt_init = `BP_CNT_INIT;
  // Instructions are word aligned, so PC bits [1:0] carry no index information.
  localparam int         c_pc_shift = 2;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
// ============================================================================
// Module : bp_sat_counter
// Brief  : 2-bit up/down saturating counter next-state function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_up,
  output logic [1:0] o_cnt_next
);

  always_comb begin
    o_cnt_next = i_cnt;
    if (i_up) begin
      if (i_cnt != ST) o_cnt_next = i_cnt + 2'b01;
    end else begin
      if (i_cnt != SNT) o_cnt_next = i_cnt - 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module : branch_predictor
// Brief  : Fetch-side gshare direction predictor trained by the D-stage resolver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS  = 6,
  parameter int GHR_BITS  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pcF,
  input  logic                 stallD,
  input  logic                 flushD,
  output logic                 pred_takenF,
  input  logic                 branchD,
  input  logic                 actual_takenD,
  output logic                 pred_takenD,
  output logic                 mispredictD,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]           r_bht [ENTRIES];
  logic [IDX_BITS-1:0]  w_idxf;
  logic [IDX_BITS-1:0]  w_hist;
  logic [IDX_BITS-1:0]  r_idxd;
  logic                 r_pred_takend;
  logic [CNT_WIDTH-1:0] r_mispredict_cnt;
  logic [1:0]           w_cnt_next;
  logic                 w_train;
  logic [31-IDX_BITS:0] w_unused_pc;

  assign w_unused_pc = {pcF[31:IDX_BITS+c_pc_shift], pcF[c_pc_shift-1:0]};
  assign w_train     = branchD & ~stallD;

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] r_ghr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ghr <= '0;
        end else if (w_train) begin
          // Shift form keeps a 1-bit history legal without a negative slice.
          r_ghr <= (r_ghr << 1) | GHR_BITS'(actual_takenD);
        end
      end

      assign w_hist = IDX_BITS'(r_ghr);
    end else begin : g_no_ghr
      assign w_hist = '0;
    end
  endgenerate

  assign w_idxf      = pcF[IDX_BITS+c_pc_shift-1:c_pc_shift] ^ w_hist;
  assign pred_takenF = r_bht[w_idxf][1];

  bp_sat_counter u_sat_counter (
    .i_cnt      (r_bht[r_idxd]),
    .i_up       (actual_takenD),
    .o_cnt_next (w_cnt_next)
  );

  // Training writes at the edge; a same-cycle lookup of this entry sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= c_cnt_init;
    end else if (w_train) begin
      r_bht[r_idxd] <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_takend <= 1'b0;
      r_idxd        <= '0;
    end else if (!stallD) begin
      if (flushD) begin
        r_pred_takend <= 1'b0;
        r_idxd        <= '0;
      end else begin
        r_pred_takend <= pred_takenF;
        r_idxd        <= w_idxf;
      end
    end
  end

  assign pred_takenD = r_pred_takend;
  assign mispredictD = branchD & (r_pred_takend ^ actual_takenD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mispredict_cnt <= '0;
    end else if (mispredictD && !stallD && (r_mispredict_cnt != '1)) begin
      r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
    end
  end

  assign mispredict_cnt = r_mispredict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module : tb_branch_predictor
// Brief  : Directed checks of bimodal (GHR_BITS=0) and gshare (GHR_BITS=4) builds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        stallD, flushD, branchD, actual_takenD;

  logic        pf0, pd0, mp0;
  logic [31:0] cnt0;
  logic        pf4, pd4, mp4;
  logic [31:0] cnt4;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(.IDX_BITS(6), .GHR_BITS(0), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .pred_takenF(pf0), .branchD(branchD), .actual_takenD(actual_takenD),
    .pred_takenD(pd0), .mispredictD(mp0), .mispredict_cnt(cnt0)
  );

  branch_predictor #(.IDX_BITS(6), .GHR_BITS(4), .CNT_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .pred_takenF(pf4), .branchD(branchD), .actual_takenD(actual_takenD),
    .pred_takenD(pd4), .mispredictD(mp4), .mispredict_cnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pcF = 32'h0; stallD = 0; flushD = 0; branchD = 0; actual_takenD = 0;

    // 1: reset state
    #12;
    pcF = 32'h0040_0000;
    #1;
    check("reset_predF0", {31'b0, pf0}, 32'd0);
    check("reset_predF4", {31'b0, pf4}, 32'd0);
    check("reset_predD", {31'b0, pd0}, 32'd0);
    check("reset_mispred", {31'b0, mp0}, 32'd0);
    check("reset_cnt", cnt0, 32'd0);
    check("reset_ghr", {28'b0, dut4.g_ghr.r_ghr}, 32'd0);
    for (int i = 0; i < 64; i++) check($sformatf("reset_bht%0d", i), {30'b0, dut0.r_bht[i]}, 32'd1);
    rst = 1'b0;

    // 2: bimodal saturation on entry 4
    pcF = 32'h0040_0010;
    tick();
    branchD = 1; actual_takenD = 1;
    #1 check("t2_pred_before", {31'b0, pf0}, 32'd0);
    tick();
    check("t2_bht_10", {30'b0, dut0.r_bht[4]}, 32'd2);
    check("t2_pred_after_T", {31'b0, pf0}, 32'd1);
    tick();
    check("t2_bht_11", {30'b0, dut0.r_bht[4]}, 32'd3);
    actual_takenD = 0;
    tick();
    check("t2_bht_dn10", {30'b0, dut0.r_bht[4]}, 32'd2);
    tick();
    check("t2_bht_dn01", {30'b0, dut0.r_bht[4]}, 32'd1);
    tick();
    check("t2_bht_dn00", {30'b0, dut0.r_bht[4]}, 32'd0);
    check("t2_pred_nt", {31'b0, pf0}, 32'd0);
    tick();
    check("t2_bht_sat0", {30'b0, dut0.r_bht[4]}, 32'd0);
    branchD = 0;

    // 3: mispredict and counter
    pulse_reset();
    branchD = 1; actual_takenD = 1;
    #1;
    check("t3_mispred", {31'b0, mp0}, 32'd1);
    check("t3_cnt0", cnt0, 32'd0);
    tick();
    check("t3_cnt1", cnt0, 32'd1);
    branchD = 0;
    #1 check("t3_nobranch_mp", {31'b0, mp0}, 32'd0);
    tick();
    check("t3_cnt_hold", cnt0, 32'd1);

    // 4: stalled branch trains once when the stall drops
    pulse_reset();
    pcF = 32'h0040_0010;
    tick();
    stallD = 1; branchD = 1; actual_takenD = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stall_bht", {30'b0, dut0.r_bht[4]}, 32'd1);
      check("t4_stall_cnt", cnt0, 32'd0);
      check("t4_stall_ghr", {28'b0, dut4.g_ghr.r_ghr}, 32'd0);
    end
    stallD = 0;
    tick();
    check("t4_bht", {30'b0, dut0.r_bht[4]}, 32'd2);
    check("t4_cnt", cnt0, 32'd1);
    check("t4_ghr", {28'b0, dut4.g_ghr.r_ghr}, 32'd1);
    branchD = 0;

    // 5: flush vs stall precedence
    tick();
    check("t5_loaded_pred", {31'b0, pd0}, 32'd1);
    check("t5_loaded_idx", {26'b0, dut0.r_idxd}, 32'd4);
    stallD = 1; flushD = 1;
    tick();
    check("t5_hold_pred", {31'b0, pd0}, 32'd1);
    check("t5_hold_idx", {26'b0, dut0.r_idxd}, 32'd4);
    stallD = 0;
    tick();
    check("t5_flush_pred", {31'b0, pd0}, 32'd0);
    check("t5_flush_idx", {26'b0, dut0.r_idxd}, 32'd0);
    flushD = 0;

    // 6: gshare history T,T,N,T then asynchronous reset
    pulse_reset();
    pcF = 32'h0040_0000;
    branchD = 1;
    actual_takenD = 1; tick();
    actual_takenD = 1; tick();
    actual_takenD = 0; tick();
    actual_takenD = 1; tick();
    branchD = 0;
    check("t6_ghr", {28'b0, dut4.g_ghr.r_ghr}, 32'hD);
    check("t6_bht0", {30'b0, dut4.r_bht[0]}, 32'd3);
    check("t6_bht1", {30'b0, dut4.r_bht[1]}, 32'd0);
    check("t6_bht3", {30'b0, dut4.r_bht[3]}, 32'd2);
    tick();
    check("t6_idx13", {26'b0, dut4.r_idxd}, 32'd13);
    #2 rst = 1'b1;
    #1;
    check("t6_async_ghr", {28'b0, dut4.g_ghr.r_ghr}, 32'd0);
    check("t6_async_bht0", {30'b0, dut4.r_bht[0]}, 32'd1);
    check("t6_async_idx", {26'b0, dut4.r_idxd}, 32'd0);
    check("t6_async_pred", {31'b0, pf4}, 32'd0);
    #1 rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
